rggen_host_arbiter: RTL and testbench
=====================================

Name: rggen_host_arbiter

Overview:
- Shares one register access channel between HOSTS host-side requesters.
- Arbitrates round-robin, latches the winning request, drives it onto the channel, and waits for the register handshake.
- Returns read data and status to the granted host.
- Sits between host bus adapters and the register blocks. It generates decode-error and timeout responses so an unclaimed access never hangs a host.

Parameters:
- HOSTS, 2, number of requesters, 1..8.
- ADDRESS_WIDTH, 16, channel address width.
- DATA_WIDTH, 32, channel data width.
- TIMEOUT, 0, cycles to wait for i_ready before responding SLAVE_ERROR; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_host_request  input  HOSTS  per-host access request, held until done
- i_host_direction  input  HOSTS  per-host direction, 0=READ 1=WRITE
- i_host_address  input  HOSTS*ADDRESS_WIDTH  packed per-host address, host k at [k*AW +: AW]
- i_host_write_data  input  HOSTS*DATA_WIDTH  packed per-host write data
- i_host_write_mask  input  HOSTS*DATA_WIDTH  packed per-host write mask
- o_host_done  output  HOSTS  one-cycle response strobe to granted host
- o_host_read_data  output  DATA_WIDTH  response read data, shared by all hosts
- o_host_status  output  2  response status: 00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
- o_request  output  1  channel request
- o_direction  output  1  channel direction
- o_address  output  ADDRESS_WIDTH  channel address
- o_write_data  output  DATA_WIDTH  channel write data
- o_write_mask  output  DATA_WIDTH  channel write mask
- i_select  input  1  OR of all register select outputs on the channel
- i_ready  input  1  OR of all register ready outputs
- i_read_data  input  DATA_WIDTH  muxed read data from the selected register
- i_status  input  2  muxed status from the selected register

Behaviour:
- Single clock domain; every state element is cleared by rst, synchronously, and clk is the only clock.
- Reset values:
  - state=IDLE, o_request=0, o_host_done=0.
  - o_direction, o_address, o_write_data, o_write_mask, o_host_read_data all 0.
  - o_host_status=00.
  - Round-robin pointer=0, so host 0 has highest priority.
- IDLE state:
  - When any i_host_request bit is set, grant the first requesting host searching upward from the pointer, wrapping modulo HOSTS.
  - Latch that host's direction, address, write data and mask into the o_* registers.
  - Move to ACCESS and clear the timeout counter.
- ACCESS state: o_request=1 and the outputs stay stable. Exits, in priority order:
  - (a) i_ready=1: capture i_read_data and i_status, then go to RESPONSE.
  - (b) i_select=0: load read data 0 and status 11 (DECODE_ERROR), then go to RESPONSE.
  - (c) TIMEOUT!=0 and counter==TIMEOUT-1 without i_ready: load read data 0 and status 10 (SLAVE_ERROR), then go to RESPONSE.
  - Otherwise increment the counter.
  - Counter width is clog2(TIMEOUT+1), minimum 1.
- RESPONSE state:
  - o_request=0 and o_host_done[grant]=1 for exactly one cycle.
  - o_host_read_data and o_host_status hold until the next RESPONSE.
  - Pointer = grant+1 modulo HOSTS.
  - Return to IDLE; a new grant is possible in the following cycle.
- Latency: request asserted at cycle 0 (IDLE), o_request at cycle 1, i_ready at cycle 1, done at cycle 2. Minimum turnaround is 3 cycles per access.
- Channel inputs are ignored outside ACCESS.
- A host that drops its request during ACCESS or RESPONSE does not abort the access; the access completes and done is still pulsed.
- Non-granted hosts' request changes have no effect until IDLE.
- Simultaneous requests: exactly one grant, chosen by the pointer. With all hosts requesting continuously, grants rotate 0,1,…,HOSTS-1,0 and no host starves.
- HOSTS=1: the pointer is a constant 0.
- Reset asserted mid-access: the next state is IDLE, o_request falls to 0, no done pulse is issued, and the pointer returns to 0.
- At most one o_host_done bit is set in any cycle; o_request and any done bit are never both set.

Test Plan:
- Reset then single write: host 0 writes addr 0x0010, data 0xDEADBEEF, mask 0xFFFFFFFF; register gives ready in the first ACCESS cycle with status 00 → o_request high for 1 cycle with latched values, o_host_done=01 one cycle later, status 00.
- Contention rotation: HOSTS=2, both hosts request reads continuously from reset, ready returned immediately → grant order 0,1,0,1 with done strobes every 3 cycles, each host receiving its own read data (0x11111111 for host 0, 0x22222222 for host 1).
- Decode error: host 1 reads 0x00FC with i_select=0 → o_host_done=10, o_host_status=11, o_host_read_data=0, one ACCESS cycle only.
- Timeout: TIMEOUT=4, i_select=1 with i_ready stuck 0 → o_request high for exactly 4 cycles, then done with status 10; with TIMEOUT=0 the access waits indefinitely until i_ready is forced at cycle 50.
- Wait states: ready delayed 3 cycles → o_address and o_write_data stable throughout ACCESS; host 0 drops its request in the second ACCESS cycle → access still completes and done is pulsed.
- Reset mid-access: assert rst in the second ACCESS cycle → next cycle o_request=0, no done pulse, and the next simultaneous 0/1 request grants host 0.

Source files
------------

// File: rtl/rggen_host_arbiter.sv
// rggen_host_arbiter
//   Shares one register access channel between HOSTS requesters. A round-robin
//   pointer picks the next host while idle; the winning request is latched onto
//   the channel, the register handshake is awaited, and the response (read data
//   and status) is returned with a one-cycle done strobe to the granted host.
//   Unclaimed accesses (no select) complete with DECODE_ERROR. When TIMEOUT is
//   non-zero, an access with no ready completes with SLAVE_ERROR.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_host_*              per-host request/direction/address/write data/mask
//   o_host_done           one-hot response strobe to the granted host
//   o_host_read_data      response read data (shared by all hosts)
//   o_host_status         response status: 00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
//   o_request..o_write_mask  register channel request side
//   i_select, i_ready, i_read_data, i_status  register channel response side
module rggen_host_arbiter #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [HOSTS-1:0]               i_host_request,
  input  logic [HOSTS-1:0]               i_host_direction,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [HOSTS*DATA_WIDTH-1:0]    i_host_write_data,
  input  logic [HOSTS*DATA_WIDTH-1:0]    i_host_write_mask,
  output logic [HOSTS-1:0]               o_host_done,
  output logic [DATA_WIDTH-1:0]          o_host_read_data,
  output logic [1:0]                     o_host_status,
  output logic                           o_request,
  output logic                           o_direction,
  output logic [ADDRESS_WIDTH-1:0]       o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_select,
  input  logic                           i_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status
);

  localparam int COUNTER_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int INDEX_WIDTH   = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  localparam logic [COUNTER_WIDTH-1:0] COUNTER_LAST =
    (TIMEOUT > 0) ? COUNTER_WIDTH'(TIMEOUT - 1) : '0;
  localparam logic [INDEX_WIDTH-1:0]   LAST_HOST    = INDEX_WIDTH'(HOSTS - 1);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] ACCESS   = 2'b01;
  localparam logic [1:0] RESPONSE = 2'b10;

  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  logic [1:0]               r_state;
  logic [INDEX_WIDTH-1:0]   r_grant;
  logic [INDEX_WIDTH-1:0]   r_pointer;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_direction;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [DATA_WIDTH-1:0]    r_write_mask;
  logic [DATA_WIDTH-1:0]    r_read_data;
  logic [1:0]               r_status;

  logic                     w_found;
  logic [INDEX_WIDTH-1:0]   w_grant;
  logic [INDEX_WIDTH-1:0]   w_next_pointer;
  logic                     w_timeout;
  logic                     w_sel_direction;
  logic [ADDRESS_WIDTH-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0]    w_sel_write_data;
  logic [DATA_WIDTH-1:0]    w_sel_write_mask;

  // Round-robin search: first look at hosts at or above the pointer, then wrap
  // around to the ones below it.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int j = 0; j < HOSTS; j++) begin
      if (!w_found && i_host_request[j] && (INDEX_WIDTH'(j) >= r_pointer)) begin
        w_found = 1'b1;
        w_grant = INDEX_WIDTH'(j);
      end
    end
    for (int j = 0; j < HOSTS; j++) begin
      if (!w_found && i_host_request[j]) begin
        w_found = 1'b1;
        w_grant = INDEX_WIDTH'(j);
      end
    end
  end

  always_comb begin
    w_sel_direction  = 1'b0;
    w_sel_address    = '0;
    w_sel_write_data = '0;
    w_sel_write_mask = '0;
    for (int j = 0; j < HOSTS; j++) begin
      if (w_grant == INDEX_WIDTH'(j)) begin
        w_sel_direction  = i_host_direction[j];
        w_sel_address    = i_host_address[j*ADDRESS_WIDTH+:ADDRESS_WIDTH];
        w_sel_write_data = i_host_write_data[j*DATA_WIDTH+:DATA_WIDTH];
        w_sel_write_mask = i_host_write_mask[j*DATA_WIDTH+:DATA_WIDTH];
      end
    end
  end

  // With a single host this is constantly zero.
  assign w_next_pointer = (r_grant == LAST_HOST) ? '0 : r_grant + 1'b1;
  assign w_timeout      = (TIMEOUT != 0) && (r_counter == COUNTER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_pointer    <= '0;
      r_counter    <= '0;
      r_direction  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_write_mask <= '0;
      r_read_data  <= '0;
      r_status     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= ACCESS;
            r_grant      <= w_grant;
            r_counter    <= '0;
            r_direction  <= w_sel_direction;
            r_address    <= w_sel_address;
            r_write_data <= w_sel_write_data;
            r_write_mask <= w_sel_write_mask;
          end
        end
        ACCESS: begin
          if (i_ready) begin
            r_state     <= RESPONSE;
            r_read_data <= i_read_data;
            r_status    <= i_status;
          end else if (!i_select) begin
            r_state     <= RESPONSE;
            r_read_data <= '0;
            r_status    <= STATUS_DECODE_ERROR;
          end else if (w_timeout) begin
            r_state     <= RESPONSE;
            r_read_data <= '0;
            r_status    <= STATUS_SLAVE_ERROR;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end
        RESPONSE: begin
          r_state   <= IDLE;
          r_pointer <= w_next_pointer;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_host_done = '0;
    if (r_state == RESPONSE) begin
      for (int j = 0; j < HOSTS; j++) begin
        o_host_done[j] = (r_grant == INDEX_WIDTH'(j));
      end
    end
  end

  assign o_request        = (r_state == ACCESS);
  assign o_direction      = r_direction;
  assign o_address        = r_address;
  assign o_write_data     = r_write_data;
  assign o_write_mask     = r_write_mask;
  assign o_host_read_data = r_read_data;
  assign o_host_status    = r_status;

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Bench for rggen_host_arbiter. Two instances share all stimulus: one with the
// timeout disabled, one with TIMEOUT=4. A behavioural model per instance
// predicts every output each cycle; directed scenarios add targeted checks,
// followed by a randomized phase.
module tb_rggen_host_arbiter;

  localparam int HOSTS = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;

  localparam int PH_IDLE   = 0;
  localparam int PH_ACCESS = 1;
  localparam int PH_RESP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [HOSTS-1:0]    h_req   = '0;
  logic [HOSTS-1:0]    h_dir   = '0;
  logic [HOSTS*AW-1:0] h_addr  = '0;
  logic [HOSTS*DW-1:0] h_wdata = '0;
  logic [HOSTS*DW-1:0] h_mask  = '0;

  logic          ch_select = 1'b0;
  logic          ch_ready  = 1'b0;
  logic [DW-1:0] ch_rdata  = '0;
  logic [1:0]    ch_status = '0;

  logic [HOSTS-1:0] d0_done,   d4_done;
  logic [DW-1:0]    d0_rdata,  d4_rdata;
  logic [1:0]       d0_status, d4_status;
  logic             d0_request, d4_request;
  logic             d0_dir,    d4_dir;
  logic [AW-1:0]    d0_address, d4_address;
  logic [DW-1:0]    d0_wdata,  d4_wdata;
  logic [DW-1:0]    d0_mask,   d4_mask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rggen_host_arbiter #(
    .HOSTS(HOSTS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .i_host_request(h_req), .i_host_direction(h_dir), .i_host_address(h_addr),
    .i_host_write_data(h_wdata), .i_host_write_mask(h_mask),
    .o_host_done(d0_done), .o_host_read_data(d0_rdata), .o_host_status(d0_status),
    .o_request(d0_request), .o_direction(d0_dir), .o_address(d0_address),
    .o_write_data(d0_wdata), .o_write_mask(d0_mask),
    .i_select(ch_select), .i_ready(ch_ready), .i_read_data(ch_rdata), .i_status(ch_status)
  );

  rggen_host_arbiter #(
    .HOSTS(HOSTS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .i_host_request(h_req), .i_host_direction(h_dir), .i_host_address(h_addr),
    .i_host_write_data(h_wdata), .i_host_write_mask(h_mask),
    .o_host_done(d4_done), .o_host_read_data(d4_rdata), .o_host_status(d4_status),
    .o_request(d4_request), .o_direction(d4_dir), .o_address(d4_address),
    .o_write_data(d4_wdata), .o_write_mask(d4_mask),
    .i_select(ch_select), .i_ready(ch_ready), .i_read_data(ch_rdata), .i_status(ch_status)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one access at a time per instance; index 0 has no timeout,
  // index 1 gives up after 4 waiting cycles.
  // ---------------------------------------------------------------------------
  int            m_phase [2] = '{PH_IDLE, PH_IDLE};
  int            m_grant [2] = '{0, 0};
  int            m_ptr   [2] = '{0, 0};
  int            m_wait  [2] = '{0, 0};
  logic          e_dir   [2];
  logic [AW-1:0] e_addr  [2];
  logic [DW-1:0] e_wdata [2];
  logic [DW-1:0] e_mask  [2];
  logic [DW-1:0] e_rdata [2];
  logic [1:0]    e_status[2];

  task automatic model_step(input int k);
    int limit;
    int g;
    int h;
    limit = (k == 0) ? 0 : 4;
    if (rst) begin
      m_phase[k] = PH_IDLE;
      m_ptr[k]   = 0;
      m_wait[k]  = 0;
      e_dir[k]   = 1'b0;
      e_addr[k]  = '0;
      e_wdata[k] = '0;
      e_mask[k]  = '0;
      e_rdata[k] = '0;
      e_status[k] = 2'b00;
      return;
    end
    case (m_phase[k])
      PH_IDLE: begin
        g = -1;
        for (int i = 0; i < HOSTS; i++) begin
          h = (m_ptr[k] + i) % HOSTS;
          if (g < 0 && h_req[h]) g = h;
        end
        if (g >= 0) begin
          m_grant[k] = g;
          m_wait[k]  = 0;
          e_dir[k]   = h_dir[g];
          e_addr[k]  = h_addr[g*AW+:AW];
          e_wdata[k] = h_wdata[g*DW+:DW];
          e_mask[k]  = h_mask[g*DW+:DW];
          m_phase[k] = PH_ACCESS;
        end
      end
      PH_ACCESS: begin
        m_wait[k]++;
        if (ch_ready) begin
          e_rdata[k] = ch_rdata;  e_status[k] = ch_status;  m_phase[k] = PH_RESP;
        end else if (!ch_select) begin
          e_rdata[k] = '0;        e_status[k] = 2'b11;      m_phase[k] = PH_RESP;
        end else if (limit != 0 && m_wait[k] == limit) begin
          e_rdata[k] = '0;        e_status[k] = 2'b10;      m_phase[k] = PH_RESP;
        end
      end
      default: begin
        m_ptr[k]   = (m_grant[k] + 1) % HOSTS;
        m_phase[k] = PH_IDLE;
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic compare_inst(input int k, input logic req, input logic dir,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic [DW-1:0] wm, input logic [HOSTS-1:0] done,
                              input logic [DW-1:0] rd, input logic [1:0] st);
    string p;
    logic [HOSTS-1:0] e_done;
    p = (k == 0) ? "t0" : "t4";
    e_done = '0;
    if (m_phase[k] == PH_RESP) e_done[m_grant[k]] = 1'b1;
    check_eq({p, "_request"},   64'(req),  64'(m_phase[k] == PH_ACCESS));
    check_eq({p, "_done"},      64'(done), 64'(e_done));
    check_eq({p, "_direction"}, 64'(dir),  64'(e_dir[k]));
    check_eq({p, "_address"},   64'(addr), 64'(e_addr[k]));
    check_eq({p, "_wdata"},     64'(wd),   64'(e_wdata[k]));
    check_eq({p, "_wmask"},     64'(wm),   64'(e_mask[k]));
    check_eq({p, "_rdata"},     64'(rd),   64'(e_rdata[k]));
    check_eq({p, "_status"},    64'(st),   64'(e_status[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_inst(0, d0_request, d0_dir, d0_address, d0_wdata, d0_mask, d0_done, d0_rdata,
                   d0_status);
      compare_inst(1, d4_request, d4_dir, d4_address, d4_wdata, d4_mask, d4_done, d4_rdata,
                   d4_status);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic set_host(input int h, input logic dir, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    h_dir[h]          = dir;
    h_addr[h*AW+:AW]  = a;
    h_wdata[h*DW+:DW] = d;
    h_mask[h*DW+:DW]  = m;
  endtask

  task automatic do_reset();
    h_req    = '0;
    ch_ready = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int last_cyc;
    int n0;
    int n4;
    logic seen4;
    logic got;

    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    check_eq("rst_request", 64'(d0_request), 64'd0);
    check_eq("rst_done",    64'(d0_done),    64'd0);
    check_eq("rst_address", 64'(d0_address), 64'd0);
    check_eq("rst_status",  64'(d0_status),  64'd0);
    check_eq("rst_rdata",   64'(d0_rdata),   64'd0);

    // Single write from host 0, ready in the first access cycle
    set_host(0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'hFFFFFFFF);
    h_req = 2'b01; ch_select = 1'b1; ch_ready = 1'b1; ch_status = 2'b00; ch_rdata = '0;
    @(negedge clk);
    check_eq("wr_request", 64'(d0_request), 64'd1);
    check_eq("wr_address", 64'(d0_address), 64'h0010);
    check_eq("wr_wdata",   64'(d0_wdata),   64'hDEADBEEF);
    check_eq("wr_dir",     64'(d0_dir),     64'd1);
    @(negedge clk);
    check_eq("wr_done",    64'(d0_done),    64'b01);
    check_eq("wr_status",  64'(d0_status),  64'd0);
    check_eq("wr_req_low", 64'(d0_request), 64'd0);
    h_req = '0;
    repeat (2) @(negedge clk);

    // Contention: both hosts read continuously, grants must alternate
    do_reset();
    set_host(0, 1'b0, 16'h0100, '0, '0);
    set_host(1, 1'b0, 16'h0200, '0, '0);
    h_req = 2'b11; ch_select = 1'b1; ch_ready = 1'b1; ch_status = 2'b00;
    ch_rdata = 32'h11111111;
    last_cyc = 0;
    for (int a = 0; a < 4; a++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        ch_rdata = (d0_address == 16'h0200) ? 32'h22222222 : 32'h11111111;
        if (|d0_done) begin
          got = 1'b1;
          check_eq("rot_grant", 64'(d0_done), (a % 2 == 0) ? 64'b01 : 64'b10);
          check_eq("rot_rdata", 64'(d0_rdata), (a % 2 == 0) ? 64'h11111111 : 64'h22222222);
          if (a > 0) check_eq("rot_spacing", 64'(cyc - last_cyc), 64'd3);
          last_cyc = cyc;
        end
      end
      if (!got) check_eq("rot_wait_expired", 64'd0, 64'd1);
    end
    h_req = '0;
    repeat (2) @(negedge clk);

    // Decode error: nobody selects host 1's address
    do_reset();
    set_host(1, 1'b0, 16'h00FC, '0, '0);
    h_req = 2'b10; ch_select = 1'b0; ch_ready = 1'b0; ch_rdata = 32'h12345678;
    @(negedge clk);
    check_eq("dec_request", 64'(d0_request), 64'd1);
    @(negedge clk);
    check_eq("dec_done",   64'(d0_done),   64'b10);
    check_eq("dec_status", 64'(d0_status), 64'b11);
    check_eq("dec_rdata",  64'(d0_rdata),  64'd0);
    h_req = '0;
    repeat (2) @(negedge clk);

    // Timeout: ready never comes until forced after 50 access cycles
    do_reset();
    set_host(0, 1'b0, 16'h0040, '0, '0);
    h_req = 2'b01; ch_select = 1'b1; ch_ready = 1'b0; ch_status = 2'b00;
    ch_rdata = 32'hCAFEF00D;
    n0 = 0; n4 = 0; seen4 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (d0_request) n0++;
      if (|d0_done) check_eq("to0_early_done", 64'(d0_done), 64'd0);
      if (!seen4) begin
        if (d4_request) n4++;
        if (|d4_done) begin
          seen4 = 1'b1;
          check_eq("to4_done",   64'(d4_done),   64'b01);
          check_eq("to4_status", 64'(d4_status), 64'b10);
          check_eq("to4_rdata",  64'(d4_rdata),  64'd0);
          h_req = '0;
        end
      end
    end
    check_eq("to4_seen",   64'(seen4), 64'd1);
    check_eq("to4_length", 64'(n4),    64'd4);
    check_eq("to0_length", 64'(n0),    64'd50);
    ch_ready = 1'b1;
    @(negedge clk);
    check_eq("to0_done",   64'(d0_done),   64'b01);
    check_eq("to0_status", 64'(d0_status), 64'b00);
    check_eq("to0_rdata",  64'(d0_rdata),  64'hCAFEF00D);
    ch_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Wait states; host 0 drops its request and changes its inputs mid-access
    do_reset();
    set_host(0, 1'b1, 16'h0123, 32'hA5A50F0F, 32'h0000FFFF);
    h_req = 2'b01; ch_select = 1'b1; ch_ready = 1'b0;
    @(negedge clk);
    check_eq("ws_addr_1", 64'(d0_address), 64'h0123);
    @(negedge clk);
    check_eq("ws_addr_2", 64'(d0_address), 64'h0123);
    h_req = '0;
    set_host(0, 1'b0, 16'hFFFF, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("ws_addr_3",  64'(d0_address), 64'h0123);
    check_eq("ws_wdata_3", 64'(d0_wdata),   64'hA5A50F0F);
    ch_ready = 1'b1; ch_rdata = 32'h0; ch_status = 2'b00;
    @(negedge clk);
    check_eq("ws_done", 64'(d0_done), 64'b01);
    ch_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the second access cycle
    do_reset();
    set_host(0, 1'b0, 16'h0A00, '0, '0);
    set_host(1, 1'b0, 16'h0B00, '0, '0);
    h_req = 2'b10; ch_select = 1'b1; ch_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mr_request", 64'(d0_request), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_req_low", 64'(d0_request), 64'd0);
    check_eq("mr_no_done", 64'(d0_done),    64'd0);
    rst = 1'b0; h_req = 2'b11;
    @(negedge clk);
    check_eq("mr_regrant", 64'(d0_address), 64'h0A00);
    h_req = '0; ch_ready = 1'b1;
    repeat (3) @(negedge clk);
    ch_ready = 1'b0;

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int h = 0; h < HOSTS; h++) begin
        h_req[h] = ($urandom_range(0, 3) != 0);
        set_host(h, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom);
      end
      ch_select = ($urandom_range(0, 7) != 0);
      ch_ready  = ($urandom_range(0, 2) == 0);
      ch_rdata  = $urandom;
      ch_status = 2'($urandom_range(0, 3));
    end
    rst = 1'b0; h_req = '0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
